// File: rtl/sram_pkg.sv
// Shared definitions for the 2-port SRAM requester-side controller.
package sram_pkg;

  localparam int SETS   = 256;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 80;
  localparam int MASK_W = 4;
  localparam int LANE_W = DATA_W / MASK_W;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Replace every lane of old_data whose mask bit is set with the lane from new_data.
  function automatic logic [DATA_W-1:0] lane_merge(
    input logic [DATA_W-1:0] old_data,
    input logic [DATA_W-1:0] new_data,
    input logic [MASK_W-1:0] mask
  );
    logic [DATA_W-1:0] result;
    result = old_data;
    for (int i = 0; i < MASK_W; i++) begin
      if (mask[i]) begin
        result[i*LANE_W +: LANE_W] = new_data[i*LANE_W +: LANE_W];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sram_init_sweeper.sv
// Post-reset index sweep: steps through every SRAM entry once, then latches done.
module sram_init_sweeper
  import sram_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] idx,
  output logic              active,
  output logic              done
);

  logic [ADDR_W-1:0] idx_reg;
  logic              done_reg;

  // Advance the index once per cycle until the last entry has been visited.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_reg  <= '0;
      done_reg <= 1'b0;
    end else if (!done_reg) begin
      idx_reg <= idx_reg + 1'b1;
      if (idx_reg == ADDR_W'(SETS - 1)) begin
        done_reg <= 1'b1;
      end
    end
  end

  assign idx    = idx_reg;
  assign active = !done_reg;
  assign done   = done_reg;

endmodule

// File: rtl/sram_2p_ctrl.sv
// Requester-side controller for a 2-port SRAM: zero sweep after reset, valid/ready
// request channels, 1-cycle read response with same-cycle write forwarding.
module sram_2p_ctrl
  import sram_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_r_valid,
  output logic              req_r_ready,
  input  logic [ADDR_W-1:0] req_r_addr,
  output logic              resp_r_valid,
  output logic [DATA_W-1:0] resp_r_data,
  input  logic              req_w_valid,
  output logic              req_w_ready,
  input  logic [ADDR_W-1:0] req_w_addr,
  input  logic [DATA_W-1:0] req_w_data,
  input  logic [MASK_W-1:0] req_w_mask,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [DATA_W-1:0] sram_r_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [DATA_W-1:0] sram_w_data,
  output logic [MASK_W-1:0] sram_w_mask
);

  state_t            state_reg;
  state_t            state_next;

  logic [ADDR_W-1:0] sweep_idx;
  logic              sweep_active;
  logic              sweep_done;

  logic              r_fire;
  logic              w_fire;
  logic              hazard_next;

  logic              fire_reg;
  logic              hazard_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [MASK_W-1:0] wmask_reg;
  logic [DATA_W-1:0] hold_reg;
  logic [DATA_W-1:0] merged_data;

  sram_init_sweeper u_sweeper (
    .clock  (clock),
    .reset  (reset),
    .idx    (sweep_idx),
    .active (sweep_active),
    .done   (sweep_done)
  );

  // State register: reset always re-enters the zero sweep.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and SRAM port drive; everything is held quiet while reset is high.
  always_comb begin
    state_next  = state_reg;
    req_r_ready = 1'b0;
    req_w_ready = 1'b0;
    sram_r_addr = '0;
    sram_w_en   = 1'b0;
    sram_w_addr = '0;
    sram_w_data = '0;
    sram_w_mask = '0;
    if (!reset) begin
      case (state_reg)
        INIT: begin
          sram_w_en   = sweep_active;
          sram_w_addr = sweep_idx;
          sram_w_mask = '1;
          if (sweep_active && (sweep_idx == ADDR_W'(SETS - 1))) begin
            state_next = RUN;
          end
        end
        RUN: begin
          req_r_ready = 1'b1;
          req_w_ready = 1'b1;
          sram_r_addr = req_r_addr;
          sram_w_en   = req_w_valid;
          sram_w_addr = req_w_addr;
          sram_w_data = req_w_data;
          sram_w_mask = req_w_mask;
        end
        default: state_next = INIT;
      endcase
    end
  end

  assign r_fire      = req_r_valid && req_r_ready;
  assign w_fire      = req_w_valid && req_w_ready;
  assign hazard_next = r_fire && w_fire && (req_r_addr == req_w_addr);

  // Response pipeline: remember whether a read fired and whether its write twin collided.
  always_ff @(posedge clock) begin
    if (reset) begin
      fire_reg   <= 1'b0;
      hazard_reg <= 1'b0;
      wdata_reg  <= '0;
      wmask_reg  <= '0;
    end else begin
      fire_reg   <= r_fire;
      hazard_reg <= hazard_next;
      wdata_reg  <= req_w_data;
      wmask_reg  <= req_w_mask;
    end
  end

  // The SRAM returns stale lanes on a collision; patch in the lanes just written.
  assign merged_data = lane_merge(sram_r_data, wdata_reg, hazard_reg ? wmask_reg : '0);

  // Keep the last delivered word so the data bus is stable between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_reg <= '0;
    end else if (fire_reg) begin
      hold_reg <= merged_data;
    end
  end

  assign resp_r_valid = fire_reg;
  assign resp_r_data  = fire_reg ? merged_data : hold_reg;
  assign init_done    = (state_reg == RUN) && sweep_done;

endmodule

// File: tb/tb_sram_2p_ctrl.sv
// Directed bench for sram_2p_ctrl with a behavioural 2-port SRAM (old data on collision).
module tb_sram_2p_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_r_valid;
  logic        req_r_ready;
  logic [7:0]  req_r_addr;
  logic        resp_r_valid;
  logic [79:0] resp_r_data;
  logic        req_w_valid;
  logic        req_w_ready;
  logic [7:0]  req_w_addr;
  logic [79:0] req_w_data;
  logic [3:0]  req_w_mask;
  logic        init_done;
  logic [7:0]  sram_r_addr;
  logic [79:0] sram_r_data;
  logic        sram_w_en;
  logic [7:0]  sram_w_addr;
  logic [79:0] sram_w_data;
  logic [3:0]  sram_w_mask;

  int checks = 0;
  int passes = 0;

  logic [79:0] mem [0:255];

  always #5 clock = ~clock;

  sram_2p_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .req_r_valid  (req_r_valid),
    .req_r_ready  (req_r_ready),
    .req_r_addr   (req_r_addr),
    .resp_r_valid (resp_r_valid),
    .resp_r_data  (resp_r_data),
    .req_w_valid  (req_w_valid),
    .req_w_ready  (req_w_ready),
    .req_w_addr   (req_w_addr),
    .req_w_data   (req_w_data),
    .req_w_mask   (req_w_mask),
    .init_done    (init_done),
    .sram_r_addr  (sram_r_addr),
    .sram_r_data  (sram_r_data),
    .sram_w_en    (sram_w_en),
    .sram_w_addr  (sram_w_addr),
    .sram_w_data  (sram_w_data),
    .sram_w_mask  (sram_w_mask)
  );

  // SRAM model: registered read, masked write; a same-address read sees old data.
  always @(posedge clock) begin
    sram_r_data <= mem[sram_r_addr];
    if (sram_w_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sram_w_mask[i]) mem[sram_w_addr][i*20 +: 20] <= sram_w_data[i*20 +: 20];
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_r_valid = 1'b0;
    req_r_addr  = 8'h00;
    req_w_valid = 1'b0;
    req_w_addr  = 8'h00;
    req_w_data  = '0;
    req_w_mask  = 4'h0;
  endtask

  // Walks 256 sweep cycles starting at index 0, checking each one, then expects init_done.
  task automatic check_sweep(input string tag);
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (sram_w_en !== 1'b1 || sram_w_addr !== 8'(k) || sram_w_data !== 80'h0 ||
          sram_w_mask !== 4'hF || req_r_ready !== 1'b0 || req_w_ready !== 1'b0 ||
          init_done !== 1'b0 || resp_r_valid !== 1'b0) begin
        if (bad < 4)
          $display("FAIL %s_cycle%0d: got en=%0b addr=%0d data=%h mask=%h rrdy=%0b wrdy=%0b done=%0b rv=%0b expected en=1 addr=%0d data=0 mask=f rrdy=0 wrdy=0 done=0 rv=0",
                   tag, k + 1, sram_w_en, sram_w_addr, sram_w_data, sram_w_mask,
                   req_r_ready, req_w_ready, init_done, resp_r_valid, k);
        bad++;
      end else begin
        passes++;
      end
      tick();
    end
    checks++;
    if (init_done !== 1'b1 || req_r_ready !== 1'b1 || req_w_ready !== 1'b1) begin
      $display("FAIL %s_done: got done=%0b rrdy=%0b wrdy=%0b expected 1 1 1",
               tag, init_done, req_r_ready, req_w_ready);
    end else begin
      passes++;
    end
    $display("sweep %s: 256 cycles walked, %0d cycle errors", tag, bad);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    checks++;
    if (req_r_ready !== 1'b0 || req_w_ready !== 1'b0 || resp_r_valid !== 1'b0 ||
        resp_r_data !== 80'h0 || init_done !== 1'b0 || sram_w_en !== 1'b0 ||
        sram_w_addr !== 8'h0 || sram_w_data !== 80'h0 || sram_w_mask !== 4'h0 ||
        sram_r_addr !== 8'h0) begin
      $display("FAIL reset_outputs: got rrdy=%0b wrdy=%0b rv=%0b rdata=%h done=%0b wen=%0b waddr=%h wdata=%h wmask=%h raddr=%h expected all zero",
               req_r_ready, req_w_ready, resp_r_valid, resp_r_data, init_done,
               sram_w_en, sram_w_addr, sram_w_data, sram_w_mask, sram_r_addr);
    end else begin
      passes++;
    end
    $display("reset: outputs sampled while reset held");
    reset = 1'b0;
    #1;
    check_sweep("init");
  endtask

  task automatic test_read_zero();
    req_r_valid = 1'b1;
    req_r_addr  = 8'h10;
    #1;
    checks++;
    if (sram_r_addr !== 8'h10 || resp_r_valid !== 1'b0) begin
      $display("FAIL read_zero_issue: got raddr=%h rv=%0b expected raddr=10 rv=0", sram_r_addr, resp_r_valid);
    end else begin
      passes++;
    end
    tick();
    req_r_valid = 1'b0;
    checks++;
    if (resp_r_valid !== 1'b1 || resp_r_data !== 80'h0) begin
      $display("FAIL read_zero_resp: got rv=%0b data=%h expected rv=1 data=0", resp_r_valid, resp_r_data);
    end else begin
      passes++;
    end
    tick();
    checks++;
    if (resp_r_valid !== 1'b0) begin
      $display("FAIL read_zero_single: got rv=%0b expected 0", resp_r_valid);
    end else begin
      passes++;
    end
    $display("read 0x10 after init: response checked");
  endtask

  task automatic test_write_then_read();
    req_w_valid = 1'b1;
    req_w_addr  = 8'h10;
    req_w_data  = 80'h1234_5678_9ABC_DEF0_1111;
    req_w_mask  = 4'hF;
    #1;
    checks++;
    if (sram_w_en !== 1'b1 || sram_w_addr !== 8'h10 ||
        sram_w_data !== 80'h1234_5678_9ABC_DEF0_1111 || sram_w_mask !== 4'hF) begin
      $display("FAIL write_pass: got en=%0b addr=%h data=%h mask=%h expected 1 10 123456789abcdef01111 f",
               sram_w_en, sram_w_addr, sram_w_data, sram_w_mask);
    end else begin
      passes++;
    end
    tick();
    req_w_valid = 1'b0;
    req_r_valid = 1'b1;
    req_r_addr  = 8'h10;
    tick();
    req_r_valid = 1'b0;
    checks++;
    if (resp_r_valid !== 1'b1 || resp_r_data !== 80'h1234_5678_9ABC_DEF0_1111) begin
      $display("FAIL write_then_read: got rv=%0b data=%h expected rv=1 data=123456789abcdef01111",
               resp_r_valid, resp_r_data);
    end else begin
      passes++;
    end
    tick();
    $display("write 0x10 then read 0x10: response checked");
  endtask

  task automatic test_forward();
    req_w_valid = 1'b1;
    req_w_addr  = 8'h20;
    req_w_data  = '1;
    req_w_mask  = 4'b0101;
    req_r_valid = 1'b1;
    req_r_addr  = 8'h20;
    tick();
    idle_inputs();
    checks++;
    if (resp_r_valid !== 1'b1 || resp_r_data !== 80'h00000_FFFFF_00000_FFFFF) begin
      $display("FAIL forward_partial: got rv=%0b data=%h expected rv=1 data=00000fffff00000fffff",
               resp_r_valid, resp_r_data);
    end else begin
      passes++;
    end
    tick();
    checks++;
    if (resp_r_valid !== 1'b0 || resp_r_data !== 80'h00000_FFFFF_00000_FFFFF) begin
      $display("FAIL forward_hold: got rv=%0b data=%h expected rv=0 data=00000fffff00000fffff",
               resp_r_valid, resp_r_data);
    end else begin
      passes++;
    end
    $display("same-cycle write/read 0x20 mask 0101: forwarding checked");
  endtask

  task automatic test_back_to_back();
    logic [79:0] exp_data [0:2];
    exp_data[0] = 80'h11111_22222_33333_44444;
    exp_data[1] = 80'hAAAAA_BBBBB_CCCCC_DDDDD;
    exp_data[2] = 80'h0F0F0_E1E1E_D2D2D_C3C3C;
    for (int i = 0; i < 3; i++) begin
      req_w_valid = 1'b1;
      req_w_addr  = 8'(i + 1);
      req_w_data  = exp_data[i];
      req_w_mask  = 4'hF;
      tick();
    end
    idle_inputs();
    req_r_valid = 1'b1;
    req_r_addr  = 8'h01;
    req_w_valid = 1'b1;
    req_w_addr  = 8'h40;
    req_w_data  = '1;
    req_w_mask  = 4'hF;
    tick();
    req_w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        req_r_addr = 8'(i + 2);
      end else begin
        req_r_valid = 1'b0;
      end
      checks++;
      if (resp_r_valid !== 1'b1 || resp_r_data !== exp_data[i]) begin
        $display("FAIL b2b_resp%0d: got rv=%0b data=%h expected rv=1 data=%h",
                 i + 1, resp_r_valid, resp_r_data, exp_data[i]);
      end else begin
        passes++;
      end
      tick();
    end
    checks++;
    if (resp_r_valid !== 1'b0) begin
      $display("FAIL b2b_end: got rv=%0b expected 0", resp_r_valid);
    end else begin
      passes++;
    end
    req_r_valid = 1'b1;
    req_r_addr  = 8'h40;
    tick();
    req_r_valid = 1'b0;
    checks++;
    if (resp_r_valid !== 1'b1 || resp_r_data !== {80{1'b1}}) begin
      $display("FAIL b2b_side_write: got rv=%0b data=%h expected rv=1 data=all ones", resp_r_valid, resp_r_data);
    end else begin
      passes++;
    end
    tick();
    $display("back-to-back reads 0x01..0x03 with write 0x40: responses checked");
  endtask

  task automatic test_reset_mid();
    req_r_valid = 1'b1;
    req_r_addr  = 8'h10;
    tick();
    req_r_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (resp_r_valid !== 1'b1 || sram_w_en !== 1'b0) begin
      $display("FAIL mid_inflight: got rv=%0b wen=%0b expected rv=1 wen=0", resp_r_valid, sram_w_en);
    end else begin
      passes++;
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (resp_r_valid !== 1'b0 || resp_r_data !== 80'h0) begin
      $display("FAIL mid_dropped: got rv=%0b data=%h expected rv=0 data=0", resp_r_valid, resp_r_data);
    end else begin
      passes++;
    end
    req_r_valid = 1'b1;
    req_r_addr  = 8'h33;
    repeat (100) tick();
    checks++;
    if (sram_w_addr !== 8'd100 || sram_w_en !== 1'b1 || resp_r_valid !== 1'b0) begin
      $display("FAIL mid_idx100: got addr=%0d en=%0b rv=%0b expected addr=100 en=1 rv=0",
               sram_w_addr, sram_w_en, resp_r_valid);
    end else begin
      passes++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_sweep("restart");
    req_r_valid = 1'b0;
    $display("reset at init index 100: sweep restart checked");
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_write_then_read();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
